cache_controller: RTL
=====================

# cache_controller

Two-way set-associative, write-through data cache between the MEM stage and the SRAM controller. It serves MEM-stage loads from on-chip lines and forwards all stores to SRAM. Its `ready` output is the MEM stage's stall source: the pipeline freezes whenever a request is outstanding and `ready` is low. It replaces direct MEM-to-SRAM access and cuts load latency on hits to zero wait cycles.

## Interface
Parameters:
- `SETS`, 64, number of sets; power of two; index width is log2(SETS).
- `TAG_W`, 10, tag width; tag is `addr[9+TAG_W-1:9]` at default `SETS`.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low.
- `rd_en`  in  1  load request from MEM stage; held stable until `ready`.
- `wr_en`  in  1  store request from MEM stage; held stable until `ready`.
- `addr`  in  32  byte address, already offset-corrected: bits [1:0] ignored, [2] word select, [8:3] index, [18:9] tag, [31:19] ignored.
- `wdata`  in  32  store data.
- `rdata`  out  32  load data; valid when `ready` is high with `rd_en` asserted.
- `ready`  out  1  request complete, or no request pending.
- `sram_rd_en`  out  1  line read request to SRAM controller.
- `sram_wr_en`  out  1  word write request to SRAM controller.
- `sram_addr`  out  32  equals `addr` for reads and writes; for reads, bit 2 is forced to 0.
- `sram_wdata`  out  32  equals `wdata`.
- `sram_rdata`  in  64  line data: [31:0] is word 0, [63:32] is word 1.
- `sram_ready`  in  1  SRAM controller access complete; 1-cycle pulse.
- `hit_count`, `miss_count`  out  32 each  present only under `CACHE_STATS_EN`.

## Operation
- Per set:
  - Two ways, each holding valid, tag, and a 64-bit line.
  - One LRU bit: 0 means way0 is the victim, 1 means way1 is the victim.
- Hit is `rd_en` AND (way0 valid with matching tag, OR way1 valid with matching tag).
- FSM states: IDLE, RD_MISS, WR.
- IDLE:
  - If `wr_en`: go to WR. Any way holding a matching valid tag is invalidated at this edge. The cache uses no-write-allocate.
  - Else if `rd_en` and hit: `rdata` is the selected word of the hit way and `ready=1` combinationally. LRU points to the other way. State stays IDLE.
  - Else if `rd_en` and miss: `ready=0`, go to RD_MISS.
  - Else: `ready=1`.
- RD_MISS:
  - `sram_rd_en=1`, `ready=0`, until `sram_ready`.
  - On `sram_ready`, the victim way is written with `sram_rdata`, valid=1, and the new tag.
  - Victim selection order: invalid way0, else invalid way1, else the LRU choice.
  - LRU then points away from the filled way.
  - `rdata` is bypassed from `sram_rdata[addr[2]*32 +: 32]`, `ready=1` for that cycle, and the next state is IDLE.
- WR:
  - `sram_wr_en=1`, `ready=0`, until `sram_ready`.
  - On `sram_ready`: `ready=1`, next state IDLE. Cache contents are unchanged.
- If `rd_en` and `wr_en` are both high, the write wins and the read is ignored.
- A request dropped mid-miss (protocol violation) is not required to be handled. The FSM still completes the SRAM access.
- `sram_addr` and `sram_wdata` are combinational from the inputs.

## Timing
- While `reset` is low:
  - Outputs: `ready=0`, `sram_rd_en=0`, `sram_wr_en=0`, `rdata=0`.
  - At the edge: state becomes IDLE; all valid bits and LRU bits clear; counters clear.
- Reset asserted mid-miss or mid-write aborts the access at the next edge. The SRAM enables drop in the same cycle.
- Read hit: 0 wait cycles. `ready` is high in the request cycle.
- Read miss: `ready` rises in the cycle `sram_ready` is seen. The pipeline therefore stalls 1 + N cycles, where N is the SRAM controller latency.
- Write: `ready` rises in the `sram_ready` cycle.
- A back-to-back request can be accepted in IDLE on the cycle after `ready`.
- A fill into a set is visible to a hit on the very next cycle.
- `sram_ready` seen in IDLE is ignored.

## Configuration
- `CACHE_STATS_EN` defined:
  - `hit_count` increments on each IDLE read hit.
  - `miss_count` increments on each RD_MISS completion.
  - Both are 32-bit, wrap modulo 2^32, and are cleared by reset.
- `CACHE_STATS_EN` undefined: both ports and both counters are absent. Functional behaviour is otherwise identical.

## Structure
- Shared package `cache_defs`: FSM state encoding (IDLE=0, RD_MISS=1, WR=2), default `SETS`, `TAG_W`, line width 64, and address field bit positions.
- Sub-module `cache_set_array`:
  - Holds tag, valid, data, and LRU storage for one way pair.
  - Combinational lookup returns hit, way, and word.
  - Write ports: fill, invalidate, and LRU update.
- The FSM stays in `cache_controller`.

## Test plan
- Cold read at `0x0000_0010`, with SRAM returning `0xBBBB_BBBB_AAAA_AAAA` after 6 cycles:
  - `ready` stays low until the `sram_ready` cycle, then `rdata=0xAAAA_AAAA`.
  - A re-read of `0x14` then hits with 0 waits and `rdata=0xBBBB_BBBB`.
- Conflict and LRU: fill `0x010` (way0) and `0x210` (way1), then re-read `0x010`, then read `0x410`:
  - `0x410` evicts `0x210`.
  - A subsequent read of `0x010` hits; a read of `0x210` misses.
- Write invalidate: read `0x20` (now cached), then write `0x20` with `0x1234_5678`:
  - `sram_wr_en` is held until `sram_ready`.
  - The next read of `0x20` misses and issues `sram_rd_en`.
- Write to an uncached address `0x40`: no fill occurs; a following read of `0x40` misses.
- Reset low during RD_MISS:
  - `sram_rd_en` drops immediately.
  - After release, a read of a previously cached address misses.
- With `CACHE_STATS_EN` defined, 3 hits and 2 misses give `hit_count=3`, `miss_count=2`. Reset returns both to 0.

Source files
------------

// File: rtl/cache_defs.sv
// Shared definitions for the two-way write-through data cache: FSM encoding,
// default geometry and address field positions.
package cache_defs;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR      = 2'd2
    } state_t;

    localparam int unsigned DEF_SETS  = 64;
    localparam int unsigned DEF_TAG_W = 10;
    localparam int unsigned LINE_W    = 64;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned WSEL_BIT  = 2;
    localparam int unsigned IDX_LSB   = 3;
endpackage

// File: rtl/cache_set_array.sv
// Tag/valid/data/LRU storage for the two ways of every set, with combinational
// lookup and fill, invalidate and LRU-touch write ports.
module cache_set_array
    import cache_defs::*;
#(
    parameter int unsigned SETS  = DEF_SETS,
    parameter int unsigned TAG_W = DEF_TAG_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [$clog2(SETS)-1:0] i_idx,
    input  logic [TAG_W-1:0]        i_tag,
    input  logic                    i_word_sel,
    input  logic                    i_fill_en,
    input  logic [LINE_W-1:0]       i_fill_data,
    input  logic                    i_inv_en,
    input  logic                    i_touch_en,
    output logic                    o_hit,
    output logic                    o_hit_way,
    output logic [WORD_W-1:0]       o_word
);
    logic [SETS-1:0]   r_valid0;
    logic [SETS-1:0]   r_valid1;
    logic [SETS-1:0]   r_lru;
    logic [TAG_W-1:0]  r_tag0  [SETS];
    logic [TAG_W-1:0]  r_tag1  [SETS];
    logic [LINE_W-1:0] r_data0 [SETS];
    logic [LINE_W-1:0] r_data1 [SETS];

    logic              w_match0;
    logic              w_match1;
    logic              w_victim;
    logic [LINE_W-1:0] w_line;

    always_comb begin
        w_match0  = r_valid0[i_idx] && (r_tag0[i_idx] == i_tag);
        w_match1  = r_valid1[i_idx] && (r_tag1[i_idx] == i_tag);
        o_hit     = w_match0 || w_match1;
        o_hit_way = !w_match0;
        w_line    = w_match0 ? r_data0[i_idx] : r_data1[i_idx];
        o_word    = i_word_sel ? w_line[LINE_W-1:WORD_W] : w_line[WORD_W-1:0];
        // Empty ways are filled before the LRU choice is consulted.
        if (!r_valid0[i_idx])      w_victim = 1'b0;
        else if (!r_valid1[i_idx]) w_victim = 1'b1;
        else                       w_victim = r_lru[i_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid0 <= '0;
            r_valid1 <= '0;
            r_lru    <= '0;
        end else if (i_fill_en) begin
            if (w_victim) r_valid1[i_idx] <= 1'b1;
            else          r_valid0[i_idx] <= 1'b1;
            r_lru[i_idx] <= !w_victim;
        end else begin
            if (i_inv_en && w_match0) r_valid0[i_idx] <= 1'b0;
            if (i_inv_en && w_match1) r_valid1[i_idx] <= 1'b0;
            if (i_touch_en)           r_lru[i_idx]    <= !o_hit_way;
        end
    end

    always_ff @(posedge clk) begin
        if (i_fill_en && !w_victim) begin
            r_tag0[i_idx]  <= i_tag;
            r_data0[i_idx] <= i_fill_data;
        end
        if (i_fill_en && w_victim) begin
            r_tag1[i_idx]  <= i_tag;
            r_data1[i_idx] <= i_fill_data;
        end
    end
endmodule

// File: rtl/cache_controller.sv
// Two-way set-associative write-through, no-write-allocate data cache between MEM
// stage and SRAM controller. Define CACHE_STATS_EN for hit/miss counter ports.
module cache_controller
    import cache_defs::*;
#(
    parameter int unsigned SETS  = DEF_SETS,
    parameter int unsigned TAG_W = DEF_TAG_W
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
`ifdef CACHE_STATS_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
`endif
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);
    localparam int unsigned IDX_W = $clog2(SETS);

    state_t            r_state;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_arr_hit;
    logic              w_hit_way;
    logic [WORD_W-1:0] w_word;
    logic              w_fill;
    logic              w_inv;
    logic              w_touch;

    assign w_idx      = addr[IDX_LSB +: IDX_W];
    assign w_tag      = addr[IDX_LSB + IDX_W +: TAG_W];
    assign sram_addr  = wr_en ? addr : {addr[31:WSEL_BIT+1], 1'b0, addr[WSEL_BIT-1:0]};
    assign sram_wdata = wdata;

    cache_set_array #(
        .SETS  (SETS),
        .TAG_W (TAG_W)
    ) u_array (
        .clk         (clock),
        .rst_n       (reset),
        .i_idx       (w_idx),
        .i_tag       (w_tag),
        .i_word_sel  (addr[WSEL_BIT]),
        .i_fill_en   (w_fill),
        .i_fill_data (sram_rdata),
        .i_inv_en    (w_inv),
        .i_touch_en  (w_touch),
        .o_hit       (w_arr_hit),
        .o_hit_way   (w_hit_way),
        .o_word      (w_word)
    );

    // Handshake outputs are decoded from the state so that hits complete with zero
    // waits and reset drops the SRAM enables within the same cycle.
    always_comb begin
        ready      = 1'b0;
        rdata      = '0;
        sram_rd_en = 1'b0;
        sram_wr_en = 1'b0;
        w_fill     = 1'b0;
        w_inv      = 1'b0;
        w_touch    = 1'b0;
        if (reset) begin
            case (r_state)
                IDLE: begin
                    if (wr_en) begin
                        w_inv = 1'b1;
                    end else if (rd_en) begin
                        if (w_arr_hit) begin
                            ready   = 1'b1;
                            rdata   = w_word;
                            w_touch = 1'b1;
                        end
                    end else begin
                        ready = 1'b1;
                    end
                end
                RD_MISS: begin
                    sram_rd_en = 1'b1;
                    if (sram_ready) begin
                        w_fill = 1'b1;
                        ready  = 1'b1;
                        rdata  = addr[WSEL_BIT] ? sram_rdata[63:32] : sram_rdata[31:0];
                    end
                end
                WR: begin
                    sram_wr_en = 1'b1;
                    if (sram_ready) ready = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (wr_en)                  r_state <= WR;
                    else if (rd_en && !w_arr_hit) r_state <= RD_MISS;
                end
                RD_MISS: if (sram_ready) r_state <= IDLE;
                WR:      if (sram_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_touch) r_hit_count  <= r_hit_count + 32'd1;
            if (w_fill)  r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif
endmodule
